// File: rtl/spoc_pkg.sv
// Shared types and default constants for the sLiSCP-light permutation sequencer.
package spoc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_STEP_END,
        ST_DONE
    } perm_state_t;

    localparam int unsigned SPOC_NUM_STEPS       = 18;
    localparam int unsigned SPOC_ROUNDS_PER_STEP = 8;

endpackage

// File: rtl/spoc_perm_sequencer_wrap_counter.sv
// Modulo-MODULUS up-counter with synchronous clear; wrap flags the terminal count.
module wrap_counter
    import spoc_pkg::*;
#(
    parameter int unsigned  MODULUS = 8,
    localparam int unsigned W       = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Wrap is decided against the parameter, never by width overflow.
    assign wrap = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spoc_perm_sequencer.sv
// Round/step sequencer for the sLiSCP-light permutation datapath.
// Define SPOC_PERM_ABORT_EN to add the abort input.
module spoc_perm_sequencer
    import spoc_pkg::*;
#(
    parameter int unsigned  NUM_STEPS       = SPOC_NUM_STEPS,
    parameter int unsigned  ROUNDS_PER_STEP = SPOC_ROUNDS_PER_STEP,
    localparam int unsigned STEP_W          = $clog2(NUM_STEPS),
    localparam int unsigned ROUND_W         = $clog2(ROUNDS_PER_STEP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SPOC_PERM_ABORT_EN
    input  logic               abort,
`endif
    output logic               load,
    output logic               en_round,
    output logic               en_step,
    output logic [ROUND_W-1:0] round_idx,
    output logic [STEP_W-1:0]  step_idx,
    output logic               busy,
    output logic               perm_done
);

    perm_state_t state_q;
    perm_state_t state_d;

    logic load_q;
    logic en_round_q;
    logic en_step_q;
    logic busy_q;
    logic done_q;

    logic abort_hit;
    logic cnt_clr;
    logic round_wrap;
    logic step_wrap;

`ifdef SPOC_PERM_ABORT_EN
    assign abort_hit = abort && (state_q != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_LOAD;
            ST_LOAD:     state_d = ST_ROUND;
            ST_ROUND:    if (round_wrap) state_d = ST_STEP_END;
            ST_STEP_END: state_d = step_wrap ? ST_DONE : ST_ROUND;
            ST_DONE:     state_d = start ? ST_LOAD : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Clearing on entry to LOAD makes the indices read zero during the LOAD cycle itself.
    assign cnt_clr = (state_d == ST_LOAD) || abort_hit;

    wrap_counter #(
        .MODULUS(ROUNDS_PER_STEP)
    ) u_round_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (state_q == ST_ROUND),
        .count(round_idx),
        .wrap (round_wrap)
    );

    wrap_counter #(
        .MODULUS(NUM_STEPS)
    ) u_step_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   ((state_q == ST_STEP_END) && !step_wrap),
        .count(step_idx),
        .wrap (step_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            load_q     <= 1'b0;
            en_round_q <= 1'b0;
            en_step_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= (state_d == ST_LOAD);
            en_round_q <= (state_d == ST_ROUND);
            en_step_q  <= (state_d == ST_STEP_END);
            busy_q     <= (state_d == ST_LOAD) || (state_d == ST_ROUND) ||
                          (state_d == ST_STEP_END);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign load      = load_q;
    assign en_round  = en_round_q;
    assign en_step   = en_step_q;
    assign busy      = busy_q;
    assign perm_done = done_q;

endmodule
